// File: rtl/karatsuba_div.sv
`default_nettype none
// ============================================================================
// Module   : karatsuba_div
// Purpose  : Iterative unsigned restoring divider, 2*WIDTH / WIDTH -> WIDTH
//            quotient and remainder, valid/ready handshake on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module karatsuba_div #(
    parameter int WIDTH = 24
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               overflow,
    output logic               div_zero
);

    localparam int c_CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [WIDTH:0]       r_prem;
    logic [WIDTH-1:0]     r_shf;
    logic [WIDTH-1:0]     r_qacc;
    logic [WIDTH-1:0]     r_dvs;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]     r_quot;
    logic [WIDTH-1:0]     r_rem;
    logic                 r_ovf;
    logic                 r_dz;

    logic [WIDTH:0]       w_trial;
    logic [WIDTH:0]       w_dvs_ext;
    logic [WIDTH:0]       w_diff;
    logic                 w_qbit;
    logic [WIDTH:0]       w_prem_next;
    logic [WIDTH-1:0]     w_qacc_next;
    logic                 w_accept;
    logic [WIDTH-1:0]     w_hi;

    assign w_hi        = dividend[2*WIDTH-1:WIDTH];
    assign w_accept    = in_valid && (r_state == IDLE);
    // R < divisor holds at every step, so the shifted-in trial fits WIDTH+1 bits
    assign w_trial     = {r_prem[WIDTH-1:0], r_shf[WIDTH-1]};
    assign w_dvs_ext   = {1'b0, r_dvs};
    assign w_diff      = w_trial - w_dvs_ext;
    assign w_qbit      = (w_trial >= w_dvs_ext);
    assign w_prem_next = w_qbit ? w_diff : w_trial;
    assign w_qacc_next = {r_qacc[WIDTH-2:0], w_qbit};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_prem  <= '0;
            r_shf   <= '0;
            r_qacc  <= '0;
            r_dvs   <= '0;
            r_cnt   <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_ovf   <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_dvs <= divisor;
                        if (divisor == '0) begin
                            r_dz    <= 1'b1;
                            r_ovf   <= 1'b1;
                            r_quot  <= '1;
                            r_rem   <= '0;
                            r_state <= DONE;
                        end else if (w_hi >= divisor) begin
                            r_dz    <= 1'b0;
                            r_ovf   <= 1'b1;
                            r_quot  <= '1;
                            r_rem   <= '0;
                            r_state <= DONE;
                        end else begin
                            r_prem  <= {1'b0, w_hi};
                            r_shf   <= dividend[WIDTH-1:0];
                            r_qacc  <= '0;
                            r_cnt   <= c_CNT_W'(WIDTH);
                            r_dz    <= 1'b0;
                            r_ovf   <= 1'b0;
                            r_state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    r_prem <= w_prem_next;
                    r_shf  <= {r_shf[WIDTH-2:0], 1'b0};
                    r_qacc <= w_qacc_next;
                    r_cnt  <= r_cnt - c_CNT_W'(1);
                    if (r_cnt == c_CNT_W'(1)) begin
                        r_quot  <= w_qacc_next;
                        r_rem   <= w_prem_next[WIDTH-1:0];
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign quotient  = r_quot;
    assign remainder = r_rem;
    assign overflow  = r_ovf;
    assign div_zero  = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_karatsuba_div.sv
`default_nettype none
// ============================================================================
// Module   : tb_karatsuba_div
// Purpose  : Directed self-checking bench for karatsuba_div (WIDTH = 24).
// Revision : 1.0 - initial release
// ============================================================================
module tb_karatsuba_div;

    localparam int WIDTH = 24;

    logic               clk_i;
    logic               rst_i;
    logic               in_valid;
    logic               in_ready;
    logic [2*WIDTH-1:0] dividend;
    logic [WIDTH-1:0]   divisor;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;
    logic               overflow;
    logic               div_zero;

    int checks   = 0;
    int failures = 0;

    karatsuba_div #(.WIDTH(WIDTH)) u_dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .overflow  (overflow),
        .div_zero  (div_zero)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Presents one operation for a single accept edge; returns #1 after it.
    task automatic present(input logic [47:0] dd, input logic [23:0] dv);
        @(negedge clk_i);
        dividend = dd;
        divisor  = dv;
        in_valid = 1'b1;
        @(posedge clk_i);
        #1;
        in_valid = 1'b0;
        dividend = '0;
        divisor  = '0;
    endtask

    // Waits for out_valid and checks latency (edges after accept) and results.
    task automatic run_op(input string tag, input logic [47:0] dd, input logic [23:0] dv,
                          input logic [23:0] eq, input logic [23:0] er,
                          input logic eovf, input logic edz, input int elat);
        int  n;
        bit  busy_ok;
        n       = 0;
        busy_ok = 1'b1;
        present(dd, dv);
        while (!out_valid && n < 100) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk_i);
            #1;
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(elat));
        check({tag, "_busy_rdy"}, 64'(busy_ok), 64'd1);
        check({tag, "_q"}, 64'(quotient), 64'(eq));
        check({tag, "_r"}, 64'(remainder), 64'(er));
        check({tag, "_flags"}, {62'd0, overflow, div_zero}, {62'd0, eovf, edz});
    endtask

    task automatic handshake(input string tag);
        @(negedge clk_i);
        out_ready = 1'b1;
        @(posedge clk_i);
        #1;
        out_ready = 1'b0;
        check({tag, "_hs"}, {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
    endtask

    initial begin
        bit stable_ok;
        rst_i     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_hs", {62'd0, in_ready, out_valid}, {62'd0, 1'b1, 1'b0});
        check("rst_qr", {16'd0, quotient, remainder}, 64'd0);
        check("rst_flags", {62'd0, overflow, div_zero}, 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        run_op("small", 48'h000000000064, 24'd7, 24'd14, 24'd2, 1'b0, 1'b0, 24);
        handshake("small");
        run_op("square", 48'hFFFFFE000001, 24'hFFFFFF, 24'hFFFFFF, 24'd0, 1'b0, 1'b0, 24);
        handshake("square");
        run_op("dz", 48'h123456789ABC, 24'd0, 24'hFFFFFF, 24'd0, 1'b1, 1'b1, 0);
        handshake("dz");
        run_op("ovf", 48'h000005000000, 24'd5, 24'hFFFFFF, 24'd0, 1'b1, 1'b0, 0);
        handshake("ovf");
        run_op("edge", 48'h000004FFFFFF, 24'd5, 24'hFFFFFF, 24'd4, 1'b0, 1'b0, 24);
        handshake("edge");
        run_op("max", 48'h7FFFFFFFFFFF, 24'h800000, 24'hFFFFFF, 24'h7FFFFF, 1'b0, 1'b0, 24);
        handshake("max");

        // Backpressure: result must hold and a new request must be ignored.
        run_op("bp", 48'h000000001234, 24'h10, 24'h123, 24'h4, 1'b0, 1'b0, 24);
        stable_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            in_valid = 1'b1;
            dividend = 48'h000000000009;
            divisor  = 24'd2;
            @(posedge clk_i);
            #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 24'h123 ||
                remainder !== 24'h4 || overflow !== 1'b0)
                stable_ok = 1'b0;
        end
        in_valid = 1'b0;
        check("bp_stable", 64'(stable_ok), 64'd1);
        handshake("bp");
        check("bp_retain", {16'd0, quotient, remainder}, {16'd0, 24'h123, 24'h4});
        run_op("bp_next", 48'h000000000009, 24'd2, 24'd4, 24'd1, 1'b0, 1'b0, 24);
        handshake("bp_next");

        // Reset in the middle of BUSY.
        present(48'h00000ABCDEF0, 24'h001234);
        repeat (10) @(posedge clk_i);
        #1;
        check("mid_busy", {62'd0, in_ready, out_valid}, {62'd0, 1'b0, 1'b0});
        rst_i = 1'b1;
        #1;
        check("mid_rst_hs", {62'd0, in_ready, out_valid}, {62'd0, 1'b1, 1'b0});
        check("mid_rst_out", {14'd0, overflow, div_zero, quotient, remainder}, 64'd0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        run_op("after_rst", 48'd1000, 24'd3, 24'd333, 24'd1, 1'b0, 1'b0, 24);
        handshake("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
